operand_stack: RTL and testbench

OPERAND_STACK -- requirements
Module: operand_stack

---
 rtl/operand_stack_if.sv | 35 +++
 rtl/operand_stack.sv | 149 ++++++++++++++
 tb/tb_operand_stack.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/operand_stack_if.sv
// Command, ALU and status signals of the operand stack, grouped for the stack
// (slave) and its controller/ALU side (master).
interface operand_stack_if #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_busy;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, push_data, alu_result,
        input  cmd_ready, alu_a, alu_b, alu_busy, pop_data, pop_valid,
               count, full, empty, err
    );

    modport slave (
        input  cmd_valid, cmd_op, push_data, alu_result,
        output cmd_ready, alu_a, alu_b, alu_busy, pop_data, pop_valid,
               count, full, empty, err
    );
endinterface

// File: rtl/operand_stack.sv
// Operand stack feeding an external combinational ALU: PUSH/POP plus
// BINOP/UNOP, which load operands, wait one OPER cycle and write the result back.
module operand_stack #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    operand_stack_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, OPER} state_e;
    typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_BINOP = 2'b10, OP_UNOP = 2'b11} op_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             err_q, err_d;
    logic             is_bin_q, is_bin_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    top_idx, sec_idx;

    assign top_idx = AW'(count_q - CW'(1));
    assign sec_idx = AW'(count_q - CW'(2));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        pop_data_d  = pop_data_q;
        is_bin_d    = is_bin_q;
        pop_valid_d = 1'b0;
        err_d       = 1'b0;
        we          = 1'b0;
        waddr       = top_idx;
        wdata       = bus.push_data;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    case (op_e'(bus.cmd_op))
                        OP_PUSH: begin
                            if (32'(count_q) < DEPTH) begin
                                we      = 1'b1;
                                waddr   = AW'(count_q);
                                count_d = count_q + CW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (count_q != '0) begin
                                pop_data_d  = mem_q[top_idx];
                                pop_valid_d = 1'b1;
                                count_d     = count_q - CW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_BINOP: begin
                            if (32'(count_q) >= 2) begin
                                alu_a_d  = mem_q[sec_idx];
                                alu_b_d  = mem_q[top_idx];
                                is_bin_d = 1'b1;
                                state_d  = OPER;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_UNOP: begin
                            if (count_q != '0) begin
                                alu_a_d  = '0;
                                alu_b_d  = mem_q[top_idx];
                                is_bin_d = 1'b0;
                                state_d  = OPER;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            OPER: begin
                // Command inputs are ignored here; the result replaces the operand(s).
                we    = 1'b1;
                wdata = bus.alu_result;
                if (is_bin_q) begin
                    waddr   = sec_idx;
                    count_d = count_q - CW'(1);
                end else begin
                    waddr = top_idx;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            err_q       <= 1'b0;
            is_bin_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            err_q       <= err_d;
            is_bin_q    <= is_bin_d;
        end
    end

    // Storage is not cleared by reset, but reset suppresses any pending write.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.alu_busy  = (state_q == OPER);
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.err       = err_q;
    assign bus.count     = count_q;
    assign bus.full      = (32'(count_q) == DEPTH);
    assign bus.empty     = (count_q == '0);
endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack with a behavioural ADD/NOT ALU model.
module tb_operand_stack;
    localparam int WIDTH = 5;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_add = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    operand_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (alu_add) bus.alu_result = bus.alu_a + bus.alu_b;
        else         bus.alu_result = ~bus.alu_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.push_data = data;
    endtask

    task automatic idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.push_data = '0;
    endtask

    initial begin
        // Reset with a PUSH presented: it must be discarded.
        cmd(2'b00, 5'd17);
        tick();
        tick();
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_ready", 32'(bus.cmd_ready), 1);
        check("rst_busy", 32'(bus.alu_busy), 0);
        check("rst_pop_valid", 32'(bus.pop_valid), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_pop_data", 32'(bus.pop_data), 0);
        check("rst_alu_a", 32'(bus.alu_a), 0);
        check("rst_alu_b", 32'(bus.alu_b), 0);
        idle();
        rst = 1'b0;
        tick();
        check("post_rst_count", 32'(bus.count), 0);

        // PUSH 3, PUSH 4, BINOP (ADD), POP -> 7
        alu_add = 1'b1;
        cmd(2'b00, 5'd3); tick();
        check("add_push1_count", 32'(bus.count), 1);
        cmd(2'b00, 5'd4); tick();
        check("add_push2_count", 32'(bus.count), 2);
        cmd(2'b10, 5'd0); tick();
        check("add_busy", 32'(bus.alu_busy), 1);
        check("add_ready_low", 32'(bus.cmd_ready), 0);
        check("add_alu_a", 32'(bus.alu_a), 3);
        check("add_alu_b", 32'(bus.alu_b), 4);
        idle(); tick();
        check("add_busy_done", 32'(bus.alu_busy), 0);
        check("add_ready_back", 32'(bus.cmd_ready), 1);
        check("add_count", 32'(bus.count), 1);
        cmd(2'b01, 5'd0); tick();
        check("add_pop_valid", 32'(bus.pop_valid), 1);
        check("add_pop_data", 32'(bus.pop_data), 7);
        check("add_empty", 32'(bus.empty), 1);
        idle(); tick();
        check("add_pop_valid_drop", 32'(bus.pop_valid), 0);

        // PUSH 5, UNOP (NOT), POP -> 26
        alu_add = 1'b0;
        cmd(2'b00, 5'd5); tick();
        cmd(2'b11, 5'd0); tick();
        check("not_busy", 32'(bus.alu_busy), 1);
        check("not_alu_a", 32'(bus.alu_a), 0);
        check("not_alu_b", 32'(bus.alu_b), 5);
        idle(); tick();
        check("not_count", 32'(bus.count), 1);
        cmd(2'b01, 5'd0); tick();
        check("not_pop_data", 32'(bus.pop_data), 26);
        check("not_pop_valid", 32'(bus.pop_valid), 1);
        idle(); tick();

        // Fill 1..8, overflow, drain 8..1, underflow
        for (int i = 1; i <= 8; i++) begin
            cmd(2'b00, WIDTH'(i)); tick();
            check("fill_count", 32'(bus.count), 32'(i));
        end
        check("fill_full", 32'(bus.full), 1);
        cmd(2'b00, 5'd9); tick();
        check("ovf_err", 32'(bus.err), 1);
        check("ovf_count", 32'(bus.count), 8);
        check("ovf_pop_valid", 32'(bus.pop_valid), 0);
        idle(); tick();
        check("ovf_err_drop", 32'(bus.err), 0);
        for (int i = 8; i >= 1; i--) begin
            cmd(2'b01, 5'd0); tick();
            check("drain_data", 32'(bus.pop_data), 32'(i));
            check("drain_valid", 32'(bus.pop_valid), 1);
        end
        cmd(2'b01, 5'd0); tick();
        check("unf_err", 32'(bus.err), 1);
        check("unf_pop_valid", 32'(bus.pop_valid), 0);
        check("unf_empty", 32'(bus.empty), 1);
        idle(); tick();

        // Single entry BINOP is rejected; operands keep 0/5 from the UNOP
        cmd(2'b00, 5'd6); tick();
        cmd(2'b10, 5'd0); tick();
        check("bin1_err", 32'(bus.err), 1);
        check("bin1_ready", 32'(bus.cmd_ready), 1);
        check("bin1_busy", 32'(bus.alu_busy), 0);
        check("bin1_count", 32'(bus.count), 1);
        check("bin1_alu_a", 32'(bus.alu_a), 0);
        check("bin1_alu_b", 32'(bus.alu_b), 5);
        cmd(2'b01, 5'd0); tick();
        check("bin1_pop_data", 32'(bus.pop_data), 6);
        check("bin1_err_clear", 32'(bus.err), 0);
        idle(); tick();

        // Reset during OPER aborts
        alu_add = 1'b1;
        cmd(2'b00, 5'd9); tick();
        cmd(2'b00, 5'd2); tick();
        cmd(2'b10, 5'd0); tick();
        check("abort_busy", 32'(bus.alu_busy), 1);
        check("abort_alu_a", 32'(bus.alu_a), 9);
        idle();
        rst = 1'b1; tick();
        rst = 1'b0;
        check("abort_count", 32'(bus.count), 0);
        check("abort_alu_a0", 32'(bus.alu_a), 0);
        check("abort_alu_b0", 32'(bus.alu_b), 0);
        check("abort_ready", 32'(bus.cmd_ready), 1);
        check("abort_err", 32'(bus.err), 0);
        tick();

        // Back-to-back with cmd_valid held: PUSH 10, PUSH 20, BINOP, PUSH 31
        cmd(2'b00, 5'd10); tick();
        cmd(2'b00, 5'd20); tick();
        cmd(2'b10, 5'd0); tick();
        check("b2b_busy", 32'(bus.alu_busy), 1);
        check("b2b_alu_b", 32'(bus.alu_b), 20);
        cmd(2'b00, 5'd31); tick();
        check("b2b_oper_ignored", 32'(bus.count), 1);
        check("b2b_ready", 32'(bus.cmd_ready), 1);
        tick();
        check("b2b_push_count", 32'(bus.count), 2);
        cmd(2'b01, 5'd0); tick();
        check("b2b_pop1", 32'(bus.pop_data), 31);
        tick();
        check("b2b_pop2", 32'(bus.pop_data), 30);
        check("b2b_empty", 32'(bus.empty), 1);
        idle(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
